bank_cmd_scheduler: RTL

- In-order DRAM command scheduler. Sits directly upstream of the DIMM command sender.
- Accepts one cache-line memory request at a time (physical address, read/write, 512-bit write data).
- Tracks the open row of every bank (open-page policy) and emits the required PRECHARGE / ACTIVATE / READ / WRITE sequence.
- Enforces precharge, activation and column-to-column spacing.

---
 rtl/mem_ctrl_pkg.sv | 47 ++++
 rtl/bank_row_table.sv | 34 +++
 rtl/bank_cmd_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared DRAM scheduler types: command encoding, address field layout and the latched request.
package mem_ctrl_pkg;

    localparam int ROW_W   = 8;
    localparam int COL_W   = 4;
    localparam int BG_W    = $clog2(2);
    localparam int BA_W    = $clog2(4);
    localparam int PADDR_W = 19;

    // Byte address layout, LSB up: offset | col | bank | bank group | row
    localparam int OFF_COL  = 3;
    localparam int OFF_BA   = OFF_COL + COL_W;
    localparam int OFF_BG   = OFF_BA + BA_W;
    localparam int OFF_ROW  = OFF_BG + BG_W;
    localparam int ADDR_TOP = OFF_ROW + ROW_W;
    localparam int FIELD_W  = ADDR_TOP - OFF_COL;

    typedef enum logic [2:0] {
        CMD_READ      = 3'd0,
        CMD_WRITE     = 3'd1,
        CMD_ACTIVATE  = 3'd2,
        CMD_PRECHARGE = 3'd3
    } cmd_e;

    typedef struct packed {
        logic              write;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [BG_W-1:0]   bg;
        logic [BA_W-1:0]   ba;
        logic [7:0][63:0]  data;
    } req_t;

    // fields holds address bits [ADDR_TOP-1:OFF_COL]
    function automatic req_t decode_req(input logic write, input logic [FIELD_W-1:0] fields,
                                        input logic [7:0][63:0] data);
        req_t r;
        r.write = write;
        r.col   = fields[0 +: COL_W];
        r.ba    = fields[OFF_BA - OFF_COL +: BA_W];
        r.bg    = fields[OFF_BG - OFF_COL +: BG_W];
        r.row   = fields[OFF_ROW - OFF_COL +: ROW_W];
        r.data  = data;
        return r;
    endfunction

endpackage

// File: rtl/bank_row_table.sv
// Open-row table: one {open, row} entry per bank, combinational lookup, single set/clear port.
module bank_row_table #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int ROW_W   = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_open,
    output logic [ROW_W-1:0] lookup_row,
    input  logic             wr_en,
    input  logic             wr_set,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ROW_W-1:0] wr_row
);

    logic [ENTRIES-1:0]            open_q;
    logic [ENTRIES-1:0][ROW_W-1:0] row_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            open_q <= '0;
            row_q  <= '0;
        end else if (wr_en) begin
            open_q[wr_idx] <= wr_set;
            if (wr_set) row_q[wr_idx] <= wr_row;
        end
    end

    assign lookup_open = open_q[lookup_idx];
    assign lookup_row  = row_q[lookup_idx];

endmodule

// File: rtl/bank_cmd_scheduler.sv
// In-order open-page DRAM command scheduler: one request in flight, emits PRE/ACT/RD/WR with tRP, tRCD and burst spacing.
module bank_cmd_scheduler
    import mem_ctrl_pkg::*;
#(
    parameter int ROW_BITS           = 8,
    parameter int COL_BITS           = 4,
    parameter int PADDR_BITS         = 19,
    parameter int BANK_GROUPS        = 2,
    parameter int BANKS_PER_GROUP    = 4,
    parameter int ACTIVATION_LATENCY = 8,
    parameter int PRECHARGE_LATENCY  = 5,
    parameter int BURST_GAP          = 4
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               req_valid_in,
    output logic                               req_ready_out,
    input  logic                               req_write_in,
    input  logic [PADDR_BITS-1:0]              req_addr_in,
    input  logic [7:0][63:0]                   req_data_in,
    output logic                               cmd_valid_out,
    output logic [2:0]                         cmd_out,
    output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
    output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
    output logic [ROW_BITS-1:0]                row_out,
    output logic [COL_BITS-1:0]                col_out,
    output logic [7:0][63:0]                   val_out
);

    localparam int MAX_LAT = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ? ACTIVATION_LATENCY
                                                                      : PRECHARGE_LATENCY;
    localparam int WAIT_W = $clog2(MAX_LAT + 1);
    localparam int GAP_W  = $clog2(BURST_GAP + 1);
    localparam logic [WAIT_W-1:0] ACT_LAT = WAIT_W'(ACTIVATION_LATENCY);
    localparam logic [WAIT_W-1:0] PRE_LAT = WAIT_W'(PRECHARGE_LATENCY);
    localparam logic [GAP_W-1:0]  GAP     = GAP_W'(BURST_GAP);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_PRE, S_WAIT_PRE, S_ACT, S_WAIT_ACT, S_COL
    } state_e;

    state_e             state;
    req_t               req;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [GAP_W-1:0]   col_cnt;
    logic               tbl_open;
    logic [ROW_W-1:0]   tbl_row;
    logic               pre_fire, act_fire, col_fire;
    logic               unused_addr;

    assign unused_addr = ^{req_addr_in[OFF_COL-1:0], req_addr_in[PADDR_BITS-1:ADDR_TOP]};

    // A command is registered on the edge where its timer steps from 1 to 0,
    // so the strobe appears in the cycle the timer reads 0.
    assign pre_fire = (state == S_PRE);
    assign act_fire = (state == S_ACT) || (state == S_WAIT_PRE && wait_cnt <= WAIT_W'(1));
    assign col_fire = (state == S_COL) && (wait_cnt <= WAIT_W'(1)) && (col_cnt <= GAP_W'(1));

    assign req_ready_out = (state == S_IDLE);

    bank_row_table #(
        .ENTRIES (BANK_GROUPS * BANKS_PER_GROUP),
        .IDX_W   (BG_W + BA_W),
        .ROW_W   (ROW_W)
    ) u_row_table (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .lookup_idx  ({req.bg, req.ba}),
        .lookup_open (tbl_open),
        .lookup_row  (tbl_row),
        .wr_en       (pre_fire | act_fire),
        .wr_set      (act_fire),
        .wr_idx      ({req.bg, req.ba}),
        .wr_row      (req.row)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= S_IDLE;
            req            <= '0;
            wait_cnt       <= '0;
            col_cnt        <= '0;
            cmd_valid_out  <= 1'b0;
            cmd_out        <= '0;
            bank_group_out <= '0;
            bank_out       <= '0;
            row_out        <= '0;
            col_out        <= '0;
            val_out        <= '0;
        end else begin
            cmd_valid_out <= pre_fire | act_fire | col_fire;
            if (pre_fire | act_fire | col_fire) begin
                bank_group_out <= req.bg;
                bank_out       <= req.ba;
                row_out        <= req.row;
            end
            if (pre_fire) cmd_out <= CMD_PRECHARGE;
            if (act_fire) cmd_out <= CMD_ACTIVATE;
            if (col_fire) begin
                cmd_out <= req.write ? CMD_WRITE : CMD_READ;
                col_out <= req.col;
                if (req.write) val_out <= req.data;
            end

            if (pre_fire)               wait_cnt <= PRE_LAT;
            else if (act_fire)          wait_cnt <= ACT_LAT;
            else if (wait_cnt != '0)    wait_cnt <= wait_cnt - WAIT_W'(1);

            if (col_fire)               col_cnt <= GAP;
            else if (col_cnt != '0)     col_cnt <= col_cnt - GAP_W'(1);

            case (state)
                S_IDLE:
                    if (req_valid_in) begin
                        req   <= decode_req(req_write_in, req_addr_in[ADDR_TOP-1:OFF_COL], req_data_in);
                        state <= S_CHECK;
                    end
                S_CHECK:
                    if (!tbl_open)              state <= S_ACT;
                    else if (tbl_row == req.row) state <= S_COL;
                    else                        state <= S_PRE;
                S_PRE:      state <= S_WAIT_PRE;
                S_WAIT_PRE: if (act_fire) state <= S_WAIT_ACT;
                S_ACT:      state <= S_WAIT_ACT;
                // Hand over to COL one cycle early so the column strobe lands exactly tRCD after ACTIVATE
                S_WAIT_ACT: if (wait_cnt <= WAIT_W'(2)) state <= S_COL;
                S_COL:      if (col_fire) state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase
        end
    end

endmodule
